// File: rtl/xbar_req_ctrl_pkg.sv
// Shared crossbar definitions: port count, grant index width, request FSM states
// and the one-hot request helper.
package xbar_req_ctrl_pkg;

  localparam int NUM_PORTS   = 4;
  localparam int GRANT_IDX_W = 2;

  typedef logic [GRANT_IDX_W-1:0] port_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_XFER = 3'd2,
    ST_REL0 = 3'd3,
    ST_REL1 = 3'd4
  } state_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t p);
    logic [NUM_PORTS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/xbar_req_ctrl_if.sv
// Crossbar-side bundle of one input port: arbiter request/grant and the data beat.
// Handshake: a beat transfers on a rising edge where oTxValid && iTxReady; while
// oTxValid is high and iTxReady is low, oTxData/oTxLast are held stable.
interface xbar_req_ctrl_if
  import xbar_req_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) ();

  logic [NUM_PORTS-1:0]             oReq;
  logic [NUM_PORTS*GRANT_IDX_W-1:0] iGrantId;
  logic [NUM_PORTS-1:0]             iGrantValid;
  logic [DATA_W-1:0]                oTxData;
  logic                             oTxValid;
  logic                             oTxLast;
  logic                             iTxReady;

  modport master (
    output oReq,
    input  iGrantId,
    input  iGrantValid,
    output oTxData,
    output oTxValid,
    output oTxLast,
    input  iTxReady
  );

  modport slave (
    input  oReq,
    output iGrantId,
    output iGrantValid,
    input  oTxData,
    input  oTxValid,
    input  oTxLast,
    output iTxReady
  );

endinterface

// File: rtl/xbar_req_ctrl_tx_reg.sv
// Single output register stage for the crossbar beat: loads on a FIFO pop,
// holds under backpressure, drops valid after a transfer with no new load.
module xbar_tx_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iLoad,
  input  logic [DATA_W-1:0] iData,
  input  logic              iLast,
  input  logic              iReady,
  output logic [DATA_W-1:0] oData,
  output logic              oValid,
  output logic              oLast
);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oData  <= '0;
      oValid <= 1'b0;
      oLast  <= 1'b0;
    end else if (iLoad) begin
      oData  <= iData;
      oLast  <= iLast;
      oValid <= 1'b1;
    end else if (oValid && iReady) begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: rtl/xbar_req_ctrl.sv
// Crossbar input-port request controller: takes a destination lookup, requests the
// destination arbiter, streams one frame from the ingress FIFO, then releases.
module xbar_req_ctrl
  import xbar_req_ctrl_pkg::*;
#(
  parameter int unsigned PORT_ID = 0,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iDstValid,
  input  port_idx_t         iDstPort,
  output logic              oDstReady,
  input  logic              iFifoEmpty,
  input  logic [DATA_W-1:0] iFifoData,
  input  logic              iFifoLast,
  output logic              oFifoRd,
  xbar_req_ctrl_if.master   bus,
  output logic              oErr,
  output state_t            oDbgState
);

  localparam port_idx_t PORT_IDX = port_idx_t'(PORT_ID);

  state_t               state;
  port_idx_t            dst;
  logic [NUM_PORTS-1:0] req_q;
  logic                 last_sent;
  logic                 xfer_first;
  logic                 granted;
  logic                 tx_fire;
  logic [DATA_W-1:0]    tx_data;
  logic                 tx_valid;
  logic                 tx_last;

  assign granted = bus.iGrantValid[dst] &&
                   (bus.iGrantId[{dst, 1'b0} +: GRANT_IDX_W] == PORT_IDX);
  assign tx_fire = tx_valid && bus.iTxReady;

  // Pop stays combinational so the show-ahead FIFO can stream at one word per
  // cycle; it is gated by reset so an abandoned frame loses no extra word.
  assign oFifoRd = (state == ST_XFER) && !iRst && !iFifoEmpty &&
                   (!tx_valid || bus.iTxReady) && !last_sent;

  assign oDstReady = (state == ST_IDLE);
  assign oDbgState = state;
  assign bus.oReq  = req_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= ST_IDLE;
      dst        <= '0;
      req_q      <= '0;
      last_sent  <= 1'b0;
      xfer_first <= 1'b0;
      oErr       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iDstValid) begin
            dst   <= iDstPort;
            req_q <= port_onehot(iDstPort);
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (granted) begin
            state      <= ST_XFER;
            xfer_first <= 1'b1;
          end
        end
        ST_XFER: begin
          // The first XFER cycle is exempt: the grant that got us here is still valid.
          xfer_first <= 1'b0;
          if (!xfer_first && !granted) oErr <= 1'b1;
          if (oFifoRd && iFifoLast) last_sent <= 1'b1;
          if (tx_fire && tx_last) begin
            state     <= ST_REL0;
            req_q     <= '0;
            last_sent <= 1'b0;
          end
        end
        // Two release cycles keep oReq low long enough for the arbiter to move on.
        ST_REL0: state <= ST_REL1;
        ST_REL1: state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          req_q <= '0;
        end
      endcase
    end
  end

  xbar_tx_reg #(
    .DATA_W(DATA_W)
  ) u_tx_reg (
    .iClk  (iClk),
    .iRst  (iRst),
    .iLoad (oFifoRd),
    .iData (iFifoData),
    .iLast (iFifoLast),
    .iReady(bus.iTxReady),
    .oData (tx_data),
    .oValid(tx_valid),
    .oLast (tx_last)
  );

  assign bus.oTxData  = tx_data;
  assign bus.oTxValid = tx_valid;
  assign bus.oTxLast  = tx_last;

endmodule

// File: tb/tb_xbar_req_ctrl.sv
// Bench for xbar_req_ctrl: FIFO model, round-robin arbiter model with a competing
// requester, and a beat scoreboard fed when frames are loaded into the FIFO.
module tb_xbar_req_ctrl;
  import xbar_req_ctrl_pkg::*;

  localparam int DATA_W  = 8;
  localparam int PORT_ID = 1;
  localparam int COMP_ID = 3;

  // clock / reset
  logic iClk = 1'b0;
  logic iRst = 1'b1;
  always #5 iClk = ~iClk;

  logic              iDstValid = 1'b0;
  port_idx_t         iDstPort  = '0;
  logic              oDstReady;
  logic              iFifoEmpty = 1'b1;
  logic [DATA_W-1:0] iFifoData  = '0;
  logic              iFifoLast  = 1'b0;
  logic              oFifoRd;
  logic              oErr;
  state_t            dbg_state;

  xbar_req_ctrl_if #(.DATA_W(DATA_W)) bus ();

  xbar_req_ctrl #(
    .PORT_ID(PORT_ID),
    .DATA_W (DATA_W)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iDstValid (iDstValid),
    .iDstPort  (iDstPort),
    .oDstReady (oDstReady),
    .iFifoEmpty(iFifoEmpty),
    .iFifoData (iFifoData),
    .iFifoLast (iFifoLast),
    .oFifoRd   (oFifoRd),
    .bus       (bus),
    .oErr      (oErr),
    .oDbgState (dbg_state)
  );

  int tests_run = 0;
  int fail_cnt  = 0;
  int pop_cnt   = 0;
  int beat_cnt  = 0;

  logic [DATA_W:0] fifo_q[$];
  logic [DATA_W:0] exp_q[$];

  // grant sources: manual values or the arbiter model
  logic       arb_en = 1'b0;
  logic [3:0] man_gv = '0;
  logic [7:0] man_gid = '0;
  logic [3:0] arb_gv;
  logic [1:0] arb_gid [4];
  logic       comp_en = 1'b0;
  logic       comp_req;
  int         comp_hold;
  int         comp_grants = 0;

  always_comb begin
    bus.iGrantValid = arb_en ? arb_gv : man_gv;
    bus.iGrantId    = arb_en ? {arb_gid[3], arb_gid[2], arb_gid[1], arb_gid[0]} : man_gid;
  end

  // round-robin arbiter model, registered grant held while the holder requests
  always @(posedge iClk) begin
    logic [3:0] r;
    logic       found;
    logic [1:0] cand;
    for (int d = 0; d < 4; d++) begin
      r          = 4'b0;
      r[PORT_ID] = bus.oReq[d];
      if (d == 0) r[COMP_ID] = comp_req;
      if (iRst) begin
        arb_gv[d]  <= 1'b0;
        arb_gid[d] <= 2'd0;
      end else if (!(arb_gv[d] && r[arb_gid[d]])) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          cand = arb_gid[d] + 2'(k);
          if (!found && r[cand]) begin
            found = 1'b1;
            arb_gid[d] <= cand;
          end
        end
        arb_gv[d] <= found;
      end
    end
  end

  // competitor on output 0: keeps a grant for 3 cycles, drops, then re-requests
  always @(posedge iClk) begin
    if (iRst || !comp_en) begin
      comp_req  <= 1'b0;
      comp_hold <= 0;
    end else if (arb_gv[0] && arb_gid[0] == 2'(COMP_ID) && comp_req) begin
      comp_grants <= comp_grants + 1;
      if (comp_hold == 2) begin
        comp_req  <= 1'b0;
        comp_hold <= 0;
      end else begin
        comp_hold <= comp_hold + 1;
      end
    end else begin
      comp_req <= 1'b1;
    end
  end

  function automatic void fifo_refresh();
    iFifoEmpty = (fifo_q.size() == 0);
    if (fifo_q.size() == 0) {iFifoLast, iFifoData} = '0;
    else                    {iFifoLast, iFifoData} = fifo_q[0];
  endfunction

  // monitor: samples just before each rising edge, scoreboard on every transfer
  logic              pend_pop = 1'b0;
  logic              hold_pending = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;

  always @(negedge iClk) begin
    logic [DATA_W:0] exp_w;
    #4;
    pend_pop = oFifoRd;
    if (oFifoRd) pop_cnt++;
    if (iRst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        tests_run++;
        if (bus.oTxValid !== 1'b1 || bus.oTxData !== hold_data || bus.oTxLast !== hold_last) begin
          fail_cnt++;
          $display("FAIL hold_stable: got valid=%0b data=%0h last=%0b, want valid=1 data=%0h last=%0b",
                   bus.oTxValid, bus.oTxData, bus.oTxLast, hold_data, hold_last);
        end
      end
      hold_pending = bus.oTxValid && !bus.iTxReady;
      hold_data    = bus.oTxData;
      hold_last    = bus.oTxLast;
      if (bus.oTxValid && bus.iTxReady) begin
        beat_cnt++;
        tests_run++;
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL beat_unexpected: got data=%0h last=%0b, want no beat", bus.oTxData, bus.oTxLast);
        end else begin
          exp_w = exp_q.pop_front();
          if ({bus.oTxLast, bus.oTxData} !== exp_w) begin
            fail_cnt++;
            $display("FAIL beat_data: got last=%0b data=%0h, want last=%0b data=%0h",
                     bus.oTxLast, bus.oTxData, exp_w[DATA_W], exp_w[DATA_W-1:0]);
          end
        end
      end
    end
  end

  always @(posedge iClk) begin
    #1;
    if (pend_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_refresh();
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(negedge iClk);
  endtask

  task automatic push_frame(input int n);
    logic [DATA_W:0] w;
    for (int i = 0; i < n; i++) begin
      w = {(i == n - 1), DATA_W'($urandom_range(0, 255))};
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    fifo_refresh();
  endtask

  task automatic send_dst(input port_idx_t p);
    int n = 0;
    while (oDstReady !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    tests_run++;
    if (oDstReady !== 1'b1) begin
      fail_cnt++;
      $display("FAIL dst_ready_wait: got oDstReady=%0b after %0d cycles, want 1", oDstReady, n);
    end
    iDstValid = 1'b1;
    iDstPort  = p;
    tick();
    iDstValid = 1'b0;
    iDstPort  = ~p;
  endtask

  task automatic wait_state(input state_t s, input int max_cyc, input string name);
    int n = 0;
    while (dbg_state !== s && n < max_cyc) begin
      tick();
      n++;
    end
    tests_run++;
    if (dbg_state !== s) begin
      fail_cnt++;
      $display("FAIL %s: got state %s, want %s within %0d cycles", name, dbg_state.name(), s.name(), max_cyc);
    end
  endtask

  task automatic wait_tx_valid(input int max_cyc, input string name);
    int n = 0;
    while (bus.oTxValid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    tests_run++;
    if (bus.oTxValid !== 1'b1) begin
      fail_cnt++;
      $display("FAIL %s: got oTxValid=%0b, want 1 within %0d cycles", name, bus.oTxValid, max_cyc);
    end
  endtask

  // scenarios
  task automatic test_reset();
    iRst      = 1'b1;
    iDstValid = 1'b0;
    repeat (3) tick();
    fifo_q.delete();
    exp_q.delete();
    fifo_refresh();
    iRst = 1'b0;
    tick();
    tests_run++;
    if (oDstReady !== 1'b1 || dbg_state !== ST_IDLE) begin
      fail_cnt++;
      $display("FAIL reset_idle: got ready=%0b state=%s, want ready=1 state=ST_IDLE", oDstReady, dbg_state.name());
    end
    tests_run++;
    if (bus.oReq !== 4'b0 || oFifoRd !== 1'b0 || oErr !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_ctrl: got req=%b rd=%0b err=%0b, want 0000 0 0", bus.oReq, oFifoRd, oErr);
    end
    tests_run++;
    if (bus.oTxValid !== 1'b0 || bus.oTxLast !== 1'b0 || bus.oTxData !== '0) begin
      fail_cnt++;
      $display("FAIL reset_tx: got valid=%0b last=%0b data=%0h, want 0 0 0", bus.oTxValid, bus.oTxLast, bus.oTxData);
    end
  endtask

  task automatic test_basic();
    int pc0, bc0;
    man_gv  = '0;
    man_gid = '0;
    bus.iTxReady = 1'b1;
    push_frame(4);
    pc0 = pop_cnt;
    bc0 = beat_cnt;
    send_dst(2'd2);
    // no grant for 3 cycles; a stray lookup must be ignored
    iDstValid = 1'b1;
    iDstPort  = 2'd0;
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if (bus.oReq !== 4'b0100 || dbg_state !== ST_REQ || oFifoRd !== 1'b0) begin
        fail_cnt++;
        $display("FAIL basic_req c%0d: got req=%b state=%s rd=%0b, want 0100 ST_REQ 0", c, bus.oReq, dbg_state.name(), oFifoRd);
      end
      tick();
    end
    iDstValid    = 1'b0;
    man_gv       = 4'b0100;
    man_gid[5:4] = 2'(PORT_ID);
    tick();
    tests_run++;
    if (dbg_state !== ST_XFER || oFifoRd !== 1'b1 || bus.oReq !== 4'b0100) begin
      fail_cnt++;
      $display("FAIL basic_first_pop: got state=%s rd=%0b req=%b, want ST_XFER 1 0100", dbg_state.name(), oFifoRd, bus.oReq);
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      tests_run++;
      if (bus.oTxValid !== 1'b1 || bus.oTxLast !== (b == 3)) begin
        fail_cnt++;
        $display("FAIL basic_beat%0d: got valid=%0b last=%0b, want 1 %0b", b, bus.oTxValid, bus.oTxLast, (b == 3));
      end
      tick();
    end
    tests_run++;
    if (dbg_state !== ST_REL0 || bus.oReq !== 4'b0) begin
      fail_cnt++;
      $display("FAIL basic_rel0: got state=%s req=%b, want ST_REL0 0000", dbg_state.name(), bus.oReq);
    end
    tick();
    tests_run++;
    if (dbg_state !== ST_REL1 || bus.oReq !== 4'b0 || oDstReady !== 1'b0) begin
      fail_cnt++;
      $display("FAIL basic_rel1: got state=%s req=%b ready=%0b, want ST_REL1 0000 0", dbg_state.name(), bus.oReq, oDstReady);
    end
    tick();
    tests_run++;
    if (oDstReady !== 1'b1 || pop_cnt - pc0 != 4 || beat_cnt - bc0 != 4 || oErr !== 1'b0) begin
      fail_cnt++;
      $display("FAIL basic_done: got ready=%0b pops=%0d beats=%0d err=%0b, want 1 4 4 0",
               oDstReady, pop_cnt - pc0, beat_cnt - bc0, oErr);
    end
    man_gv = '0;
  endtask

  task automatic test_backpressure();
    int  pc0, bc0;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    push_frame(5);
    pc0 = pop_cnt;
    bc0 = beat_cnt;
    man_gid      = '0;
    man_gid[3:2] = 2'(PORT_ID);
    man_gv       = 4'b0010;
    send_dst(2'd1);
    wait_tx_valid(10, "bp_first_beat");
    for (int i = 0; i < 4; i++) begin
      bus.iTxReady = pat[i];
      tick();
    end
    bus.iTxReady = 1'b1;
    wait_state(ST_REL0, 20, "bp_rel0");
    tests_run++;
    if (pop_cnt - pc0 != 5 || beat_cnt - bc0 != 5 || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL bp_counts: got pops=%0d beats=%0d left=%0d, want 5 5 0", pop_cnt - pc0, beat_cnt - bc0, exp_q.size());
    end
    man_gv = '0;
    wait_state(ST_IDLE, 5, "bp_idle");
  endtask

  task automatic test_single();
    int pc0, bc0;
    push_frame(1);
    pc0 = pop_cnt;
    bc0 = beat_cnt;
    man_gid      = '0;
    man_gid[7:6] = 2'(PORT_ID);
    man_gv       = 4'b1000;
    send_dst(2'd3);
    wait_tx_valid(10, "single_beat");
    tests_run++;
    if (bus.oTxLast !== 1'b1) begin
      fail_cnt++;
      $display("FAIL single_last: got oTxLast=%0b, want 1", bus.oTxLast);
    end
    tick();
    tests_run++;
    if (dbg_state !== ST_REL0 || beat_cnt - bc0 != 1 || pop_cnt - pc0 != 1) begin
      fail_cnt++;
      $display("FAIL single_rel0: got state=%s beats=%0d pops=%0d, want ST_REL0 1 1", dbg_state.name(), beat_cnt - bc0, pop_cnt - pc0);
    end
    tick();
    tests_run++;
    if (dbg_state !== ST_REL1) begin
      fail_cnt++;
      $display("FAIL single_rel1: got state=%s, want ST_REL1", dbg_state.name());
    end
    tick();
    tests_run++;
    if (dbg_state !== ST_IDLE || bus.oTxValid !== 1'b0) begin
      fail_cnt++;
      $display("FAIL single_idle: got state=%s valid=%0b, want ST_IDLE 0", dbg_state.name(), bus.oTxValid);
    end
    man_gv = '0;
  endtask

  task automatic test_grant_loss();
    int bc0;
    push_frame(4);
    bc0 = beat_cnt;
    man_gid      = '0;
    man_gid[1:0] = 2'(PORT_ID);
    man_gv       = 4'b0001;
    send_dst(2'd0);
    wait_tx_valid(10, "loss_first_beat");
    tests_run++;
    if (oErr !== 1'b0) begin
      fail_cnt++;
      $display("FAIL loss_err_before: got oErr=%0b, want 0", oErr);
    end
    man_gid[1:0] = 2'(PORT_ID + 1);
    tick();
    tests_run++;
    if (oErr !== 1'b1) begin
      fail_cnt++;
      $display("FAIL loss_err_set: got oErr=%0b, want 1", oErr);
    end
    wait_state(ST_REL0, 20, "loss_rel0");
    tests_run++;
    if (beat_cnt - bc0 != 4 || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL loss_beats: got beats=%0d left=%0d, want 4 0", beat_cnt - bc0, exp_q.size());
    end
    man_gv = '0;
    repeat (4) tick();
    tests_run++;
    if (oErr !== 1'b1 || dbg_state !== ST_IDLE) begin
      fail_cnt++;
      $display("FAIL loss_err_sticky: got oErr=%0b state=%s, want 1 ST_IDLE", oErr, dbg_state.name());
    end
    test_reset();
  endtask

  task automatic test_reset_mid();
    int pc0, bc0, pc1, n;
    push_frame(5);
    pc0 = pop_cnt;
    bc0 = beat_cnt;
    man_gid      = '0;
    man_gid[5:4] = 2'(PORT_ID);
    man_gv       = 4'b0100;
    send_dst(2'd2);
    n = 0;
    while (beat_cnt - bc0 < 2 && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (beat_cnt - bc0 != 2 || pop_cnt - pc0 != 3) begin
      fail_cnt++;
      $display("FAIL rstmid_progress: got beats=%0d pops=%0d, want 2 3", beat_cnt - bc0, pop_cnt - pc0);
    end
    iRst = 1'b1;
    pc1  = pop_cnt;
    tick();
    tests_run++;
    if (bus.oReq !== 4'b0 || bus.oTxValid !== 1'b0 || oFifoRd !== 1'b0 || dbg_state !== ST_IDLE) begin
      fail_cnt++;
      $display("FAIL rstmid_outputs: got req=%b valid=%0b rd=%0b state=%s, want 0000 0 0 ST_IDLE",
               bus.oReq, bus.oTxValid, oFifoRd, dbg_state.name());
    end
    repeat (2) tick();
    tests_run++;
    if (pop_cnt != pc1) begin
      fail_cnt++;
      $display("FAIL rstmid_no_pop: got %0d extra pops, want 0", pop_cnt - pc1);
    end
    fifo_q.delete();
    exp_q.delete();
    fifo_refresh();
    man_gv = '0;
    iRst   = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int bc0, cg0;
    arb_en  = 1'b1;
    comp_en = 1'b1;
    push_frame(3);
    push_frame(3);
    bc0 = beat_cnt;
    send_dst(2'd0);
    wait_state(ST_REL0, 40, "b2b_rel0_a");
    tests_run++;
    if (beat_cnt - bc0 != 3 || bus.oReq !== 4'b0) begin
      fail_cnt++;
      $display("FAIL b2b_frame_a: got beats=%0d req=%b, want 3 0000", beat_cnt - bc0, bus.oReq);
    end
    cg0 = comp_grants;
    send_dst(2'd0);
    wait_state(ST_XFER, 40, "b2b_xfer_b");
    tests_run++;
    if (comp_grants <= cg0) begin
      fail_cnt++;
      $display("FAIL b2b_comp_gap: got %0d competitor grant cycles in gap, want >0", comp_grants - cg0);
    end
    wait_state(ST_REL0, 40, "b2b_rel0_b");
    tests_run++;
    if (beat_cnt - bc0 != 6 || exp_q.size() != 0 || oErr !== 1'b0) begin
      fail_cnt++;
      $display("FAIL b2b_frame_b: got beats=%0d left=%0d err=%0b, want 6 0 0", beat_cnt - bc0, exp_q.size(), oErr);
    end
    comp_en = 1'b0;
    wait_state(ST_IDLE, 5, "b2b_idle");
    arb_en = 1'b0;
  endtask

  initial begin
    bus.iTxReady = 1'b1;
    fifo_refresh();
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_grant_loss();
    test_reset_mid();
    test_back_to_back();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
